// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store buffer: FSM state encoding
// and default data/address widths.
package dm_pkg;

    localparam int DM_DW = 16;
    localparam int DM_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_fifo.sv
// Circular store-entry FIFO with count-register based full/empty; pointers
// wrap naturally because DEPTH is a power of two.
module dm_fifo
    import dm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DM_DW,
    parameter int AW    = DM_AW,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] head_ptr_r;
    logic [PW-1:0] tail_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign count     = count_r;
    assign head_addr = addr_mem_r[head_ptr_r];
    assign head_data = data_mem_r[head_ptr_r];

    // Entry storage: written at the tail on an accepted push, never reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            addr_mem_r[tail_ptr_r] <= push_addr;
            data_mem_r[tail_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count; reset discards all entries.
    always_ff @(posedge clock) begin
        if (rst) begin
            head_ptr_r <= {PW{1'b0}};
            tail_ptr_r <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_ptr_r <= tail_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                head_ptr_r <= head_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer draining to data memory through a shared arbiter.
// Optional macro DM_STORE_STATS_EN adds a 16-bit commit counter output.
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DM_DW,
    parameter int AW    = DM_AW
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          mem_req,
    input  logic          mem_grant,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
`ifdef DM_STORE_STATS_EN
    output logic [DW-1:0] mem_data,
    output logic [15:0]   commit_cnt
`else
    output logic [DW-1:0] mem_data
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    dm_state_e     state_r;
    dm_state_e     state_next_s;
    logic [CW-1:0] count_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_data_s;
    logic          push_ok_s;
    logic          pop_s;
    logic          entries_left_s;
    logic          overflow_r;
    logic          mem_req_r;
    logic          mem_wr_en_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_data_r;
    logic          req_next_s;
    logic          wr_next_s;
    logic [AW-1:0] addr_next_s;
    logic [DW-1:0] data_next_s;

    assign push_ok_s      = st_valid && !full;
    assign pop_s          = (state_r == ST_WRITE);
    assign entries_left_s = (count_s > CW'(1'b1)) || push_ok_s;

    dm_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW),
        .CW    (CW)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push_ok_s),
        .push_addr (st_addr),
        .push_data (st_data),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .count     (count_s),
        .full      (full),
        .empty     (empty)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_grant) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WRITE: begin
                if (entries_left_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, computed for the upcoming state so outputs can be registered.
    // The head cannot move between REQ and WRITE, so sampling it on entry is safe.
    always_comb begin
        req_next_s  = 1'b0;
        wr_next_s   = 1'b0;
        addr_next_s = {AW{1'b0}};
        data_next_s = {DW{1'b0}};
        case (state_next_s)
            ST_REQ:   req_next_s = 1'b1;
            ST_WRITE: begin
                wr_next_s   = 1'b1;
                addr_next_s = head_addr_s;
                data_next_s = head_data_s;
            end
            default: begin
                req_next_s = 1'b0;
                wr_next_s  = 1'b0;
            end
        endcase
    end

    // Registered memory-side outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_wr_en_r <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_data_r  <= {DW{1'b0}};
        end else begin
            mem_req_r   <= req_next_s;
            mem_wr_en_r <= wr_next_s;
            mem_addr_r  <= addr_next_s;
            mem_data_r  <= data_next_s;
        end
    end

    // Sticky overflow: a store arrived while full, regardless of a same-cycle pop.
    always_ff @(posedge clock) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (st_valid && full) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow  = overflow_r;
    assign mem_req   = mem_req_r;
    assign mem_wr_en = mem_wr_en_r;
    assign mem_addr  = mem_addr_r;
    assign mem_data  = mem_data_r;

`ifdef DM_STORE_STATS_EN
    logic [15:0] commit_cnt_r;

    // Commit counter: one per WRITE closing edge, wraps naturally.
    always_ff @(posedge clock) begin
        if (rst) begin
            commit_cnt_r <= 16'd0;
        end else if (state_r == ST_WRITE) begin
            commit_cnt_r <= commit_cnt_r + 16'd1;
        end
    end

    assign commit_cnt = commit_cnt_r;
`endif

endmodule
